float_divider: RTL and testbench

- Sequential block-floating-point divider, the inverse operation of float_multiplier.
- Inputs are two operands (signed integer mantissa, signed exponent; value = M * 2^E). Output is a normalized quotient in the same mantissa/exponent format.
- Used in the FFT datapath for scaling and normalization, where a divide is needed. It shares float_multiplier's operand widths and a 15-bit result mantissa.
- Uses a start/busy/done handshake and a restoring long-division core.

---
 rtl/float_divider_if.sv | 32 +++
 rtl/float_divider.sv | 155 +++++++++++++++
 tb/tb_float_divider.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/float_divider_if.sv
// Operand/result bundle for float_divider:
// start request and operands in, busy/done and quotient out.
interface float_divider_if #(
    parameter int MANT_W = 10,
    parameter int EXP_W  = 5,
    parameter int Q_W    = 15
);
    logic              iStart;
    logic [MANT_W-1:0] iMant1;
    logic [EXP_W-1:0]  iExp1;
    logic [MANT_W-1:0] iMant2;
    logic [EXP_W-1:0]  iExp2;
    logic              oBusy;
    logic              oDone;
    logic [Q_W-1:0]    oMantQ;
    logic [EXP_W-1:0]  oExpQ;
    logic              oDivZero;
    logic              oOvf;
    logic              oUnf;

    modport master (
        output iStart, iMant1, iExp1, iMant2, iExp2,
        input  oBusy, oDone, oMantQ, oExpQ,
        input  oDivZero, oOvf, oUnf
    );

    modport slave (
        input  iStart, iMant1, iExp1, iMant2, iExp2,
        output oBusy, oDone, oMantQ, oExpQ,
        output oDivZero, oOvf, oUnf
    );
endinterface

// File: rtl/float_divider.sv
// Sequential block-floating-point divider (M*2^E format),
// restoring long division on left-aligned magnitudes.
module float_divider #(
    parameter int MANT_W = 10,
    parameter int EXP_W  = 5,
    parameter int Q_W    = 15
) (
    input  logic           clkExt,
    input  logic           iRst_n,
    float_divider_if.slave bus
);
    localparam int QB  = Q_W - 1;
    localparam int CW  = $clog2(QB);
    localparam int LZW = $clog2(MANT_W);
    localparam int EW  = 8;
    localparam logic signed [EW-1:0] EMAX = EW'(2**(EXP_W-1) - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(-(2**(EXP_W-1)));
    localparam logic [QB-1:0] MAG_MAX = '1;

    typedef enum logic [2:0] {IDLE, LOAD, DIV, NORM, DONE} state_t;

    state_t               state_q;
    logic [MANT_W-1:0]    m1_q, m2_q, bn_q;
    logic [EXP_W-1:0]     e1_q, e2_q, expq_q, expq_d;
    logic                 sign_q;
    logic [MANT_W:0]      rem_q, rem_d, rem_sub;
    logic [QB-1:0]        quo_q, quo_d;
    logic [CW-1:0]        cnt_q;
    logic signed [EW-1:0] exp_q, exp_ld, exp_n;
    logic [Q_W-1:0]       mant_q, mant_d, dz_mant;
    logic                 done_q, dz_q, ovf_q, unf_q;
    logic                 ovf_d, unf_d, ge;

    logic [MANT_W-1:0]    a_mag, b_mag, a_n, b_n;
    logic [LZW-1:0]       sa, sb;
    logic [QB-1:0]        mag_n, mag_sel;

    function automatic logic [LZW-1:0] lzc(input logic [MANT_W-1:0] v);
        lzc = '0;
        for (int i = 0; i < MANT_W; i++)
            if (v[i]) lzc = LZW'(MANT_W - 1 - i);
    endfunction

    always_comb begin
        a_mag  = m1_q[MANT_W-1] ? -m1_q : m1_q;
        b_mag  = m2_q[MANT_W-1] ? -m2_q : m2_q;
        sa     = lzc(a_mag);
        sb     = lzc(b_mag);
        a_n    = a_mag << sa;
        b_n    = b_mag << sb;
        exp_ld = EW'($signed(e1_q)) - EW'($signed(e2_q))
               + EW'(sb) - EW'(sa) - EW'(QB - 1);
        // Divide-by-zero saturates toward the dividend's sign.
        dz_mant = (m1_q == '0)     ? '0 :
                  m1_q[MANT_W-1]   ? -{1'b0, MAG_MAX} :
                                     {1'b0, MAG_MAX};
        ge      = rem_q >= {1'b0, bn_q};
        rem_sub = ge ? rem_q - {1'b0, bn_q} : rem_q;
        rem_d   = rem_sub << 1;
        quo_d   = {quo_q[QB-2:0], ge};
        mag_n   = quo_q[QB-1] ? quo_q : {quo_q[QB-2:0], 1'b0};
        exp_n   = quo_q[QB-1] ? exp_q : exp_q - EW'(1);
        ovf_d   = exp_n > EMAX;
        unf_d   = exp_n < EMIN;
        mag_sel = ovf_d ? MAG_MAX : (unf_d ? '0 : mag_n);
        mant_d  = sign_q ? -{1'b0, mag_sel} : {1'b0, mag_sel};
        expq_d  = ovf_d ? EMAX[EXP_W-1:0] :
                  (unf_d ? '0 : exp_n[EXP_W-1:0]);
    end

    always_ff @(posedge clkExt or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            m1_q    <= '0;
            m2_q    <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            bn_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
            expq_q  <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus.iStart) begin
                    m1_q    <= bus.iMant1;
                    e1_q    <= bus.iExp1;
                    m2_q    <= bus.iMant2;
                    e2_q    <= bus.iExp2;
                    state_q <= LOAD;
                end
                LOAD: begin
                    sign_q <= m1_q[MANT_W-1] ^ m2_q[MANT_W-1];
                    if (b_mag == '0) begin
                        mant_q  <= dz_mant;
                        expq_q  <= EMAX[EXP_W-1:0];
                        dz_q    <= 1'b1;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (a_mag == '0) begin
                        mant_q  <= '0;
                        expq_q  <= '0;
                        dz_q    <= 1'b0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rem_q   <= {1'b0, a_n};
                        bn_q    <= b_n;
                        quo_q   <= '0;
                        cnt_q   <= CW'(QB - 1);
                        exp_q   <= exp_ld;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) state_q <= NORM;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                NORM: begin
                    mant_q  <= mant_d;
                    expq_q  <= expq_d;
                    dz_q    <= 1'b0;
                    ovf_q   <= ovf_d;
                    unf_q   <= unf_d;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oBusy    = state_q != IDLE;
    assign bus.oDone    = done_q;
    assign bus.oMantQ   = mant_q;
    assign bus.oExpQ    = expq_q;
    assign bus.oDivZero = dz_q;
    assign bus.oOvf     = ovf_q;
    assign bus.oUnf     = unf_q;
endmodule

// File: tb/tb_float_divider.sv
// Scoreboard bench for float_divider: directed cases plus
// random operands checked against an arithmetic reference.
module tb_float_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;

    typedef struct {
        int mant;
        int expo;
        int dz;
        int ovf;
        int unf;
        int lat;
        int start;
    } exp_t;

    exp_t sb_q[$];

    float_divider_if #(.MANT_W(10), .EXP_W(5), .Q_W(15)) bus();

    float_divider #(.MANT_W(10), .EXP_W(5), .Q_W(15)) dut (
        .clkExt (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int msb(input int x);
        int r = 0;
        while (x > 1) begin
            x = x >>> 1;
            r++;
        end
        return r;
    endfunction

    // Quotient = |M1|/|M2| scaled so that the leading bits line up,
    // then normalized into [2^13, 2^14) with truncation throughout.
    function automatic exp_t model(input int m1, e1, m2, e2);
        exp_t   r;
        int     a, b, k, e, mag;
        longint q;
        r = '{mant: 0, expo: 0, dz: 0, ovf: 0, unf: 0, lat: 2, start: 0};
        if (m2 == 0) begin
            r.dz   = 1;
            r.expo = 15;
            r.mant = (m1 > 0) ? 16383 : ((m1 < 0) ? -16383 : 0);
            return r;
        end
        if (m1 == 0) return r;
        a = (m1 < 0) ? -m1 : m1;
        b = (m2 < 0) ? -m2 : m2;
        k = 13 + msb(b) - msb(a);
        q = (longint'(a) << k) / longint'(b);
        e = e1 - e2 - k;
        if (q < 8192) begin
            q = q * 2;
            e = e - 1;
        end
        if (e > 15) begin
            r.ovf = 1; mag = 16383; r.expo = 15;
        end else if (e < -16) begin
            r.unf = 1; mag = 0; r.expo = 0;
        end else begin
            mag = int'(q); r.expo = e;
        end
        r.mant = ((m1 < 0) != (m2 < 0)) ? -mag : mag;
        r.lat  = 17;
        return r;
    endfunction

    task automatic issue(input int m1, e1, m2, e2, input bit push);
        exp_t x;
        int   w = 0;
        while (bus.oBusy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (bus.oBusy) chk("issue_wait_idle", 1, 0);
        bus.iStart = 1'b1;
        bus.iMant1 = 10'(m1);
        bus.iExp1  = 5'(e1);
        bus.iMant2 = 10'(m2);
        bus.iExp2  = 5'(e2);
        if (push) begin
            x = model(m1, e1, m2, e2);
            x.start = cyc + 1;
            sb_q.push_back(x);
        end
        @(negedge clk);
        bus.iStart = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.oBusy) busy_cnt++;
            if (bus.oDone) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    x = sb_q.pop_front();
                    chk("mant", int'($signed(bus.oMantQ)), x.mant);
                    chk("exp", int'($signed(bus.oExpQ)), x.expo);
                    chk("divzero", int'(bus.oDivZero), x.dz);
                    chk("ovf", int'(bus.oOvf), x.ovf);
                    chk("unf", int'(bus.oUnf), x.unf);
                    chk("latency", cyc + 1 - x.start, x.lat);
                    chk("busy_cycles", busy_cnt, x.lat);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_mant"}, int'(bus.oMantQ), 0);
        chk({tag, "_exp"}, int'(bus.oExpQ), 0);
        chk({tag, "_busy"}, int'(bus.oBusy), 0);
        chk({tag, "_done"}, int'(bus.oDone), 0);
        chk({tag, "_dz"}, int'(bus.oDivZero), 0);
        chk({tag, "_ovf"}, int'(bus.oOvf), 0);
        chk({tag, "_unf"}, int'(bus.oUnf), 0);
    endtask

    initial begin
        int m1, e1, m2, e2;
        bus.iStart = 1'b0;
        bus.iMant1 = '0;
        bus.iExp1  = '0;
        bus.iMant2 = '0;
        bus.iExp2  = '0;
        #1 rst_n = 1'b0;
        #11 chk_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1, 0, 1, 0, 1);
        issue(-3, 2, 2, 0, 1);
        issue(1, 0, 3, 0, 1);
        issue(5, 0, 0, 0, 1);
        issue(-5, 3, 0, -2, 1);
        issue(0, 4, 0, 1, 1);
        issue(0, 7, -9, 2, 1);
        issue(511, 15, 1, -16, 1);
        issue(1, 0, 1, 0, 1);
        issue(1, -16, 511, 15, 1);
        issue(-512, 0, -512, 0, 1);
        issue(-512, 1, 1, 0, 1);

        // A start pulse while busy must not launch a second divide.
        issue(7, 1, 3, -2, 1);
        repeat (3) @(negedge clk);
        bus.iStart = 1'b1;
        bus.iMant1 = 10'd100;
        bus.iMant2 = 10'd9;
        @(negedge clk);
        bus.iStart = 1'b0;

        // Abort in the middle of the division loop.
        issue(300, 2, -7, 1, 0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1, 0, 1, 0, 1);

        for (int i = 0; i < 200; i++) begin
            m1 = int'($urandom_range(0, 1023)) - 512;
            m2 = int'($urandom_range(0, 1023)) - 512;
            e1 = int'($urandom_range(0, 31)) - 16;
            e2 = int'($urandom_range(0, 31)) - 16;
            if ($urandom_range(0, 15) == 0) m1 = 0;
            if ($urandom_range(0, 15) == 0) m2 = 0;
            issue(m1, e1, m2, e2, 1);
        end

        for (int i = 0; i < 100 && sb_q.size() != 0; i++)
            @(negedge clk);
        chk("pending_results", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
